// File: rtl/apb_pkg.sv
// Shared types and constants for the APB slave front-end.
// FSM encoding, address geometry and the register-select helper.
package apb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } apb_state_e;

  localparam int ADDR_LSB = 2;
  localparam int WCNT_W   = 4;
  localparam int MAX_REGS = 32;

  function automatic logic [MAX_REGS-1:0] onehot(
    input int idx,
    input int n
  );
    logic [MAX_REGS-1:0] v;
    v = '0;
    if (idx >= 0 && idx < n && idx < MAX_REGS)
      v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/apb_rdmux.sv
// Read-data slice select for the register bank.
// Indices past the last register return zero.
module apb_rdmux
  import apb_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int REGRN  = 3,
  parameter int IW     = 6
) (
  input  logic [DWIDTH*REGRN-1:0] rd_data_i,
  input  logic [IW-1:0]           idx_i,
  output logic [DWIDTH-1:0]       data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < REGRN; i++) begin
      if (int'(idx_i) == i)
        data_o = rd_data_i[i*DWIDTH +: DWIDTH];
    end
  end

endmodule

// File: rtl/apb_slave_ctrl.sv
// APB slave front-end: address decode, SETUP/ACCESS tracking,
// programmable wait states, write strobe and read-data return.
module apb_slave_ctrl
  import apb_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int REGRN  = 3,
  parameter int AWIDTH = 8,
  parameter int WAITS  = 1
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [AWIDTH-1:0]       PADDR,
  input  logic [DWIDTH-1:0]       PWDATA,
  input  logic [DWIDTH*REGRN-1:0] rd_data,
  output logic [REGRN-1:0]        pselr,
  output logic                    wr_en,
  output logic [DWIDTH-1:0]       wr_data,
  output logic [DWIDTH-1:0]       PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int IW = AWIDTH - ADDR_LSB;
  localparam logic [WCNT_W-1:0] WLOAD = WCNT_W'(WAITS);
  localparam logic [WCNT_W-1:0] ONE   = WCNT_W'(1);

  apb_state_e        state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]     idx, idx_q, idx_d;
  logic              addr_ok, ok_q, ok_d;
  logic              wr_q, wr_d;
  logic              setup_hit, done;
  logic              rdy_q, err_q, wen_q;
  logic [DWIDTH-1:0] wdat_q, wdat_d;
  logic [DWIDTH-1:0] rdat_q, rdat_d;
  logic [DWIDTH-1:0] mux_data;

  assign idx       = PADDR[AWIDTH-1:ADDR_LSB];
  assign addr_ok   = (PADDR[ADDR_LSB-1:0] == '0)
                  && (int'(idx) < REGRN);
  assign setup_hit = PSEL && !PENABLE;

  // Reset also blanks the select so register stages stay quiet.
  assign pselr = (PRESETn && PSEL && addr_ok)
               ? REGRN'(onehot(int'(idx), REGRN))
               : '0;

  apb_rdmux #(
    .DWIDTH (DWIDTH),
    .REGRN  (REGRN),
    .IW     (IW)
  ) u_rdmux (
    .rd_data_i (rd_data),
    .idx_i     (idx_q),
    .data_o    (mux_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ok_d    = ok_q;
    wr_d    = wr_q;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (setup_hit)
          state_d = S_SETUP;
      end
      S_SETUP: begin
        if (!PSEL) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ACCESS;
          cnt_d   = WLOAD;
          done    = (WLOAD == '0);
        end
      end
      S_ACCESS: begin
        // cnt_q==0 means this is the PREADY cycle.
        if (cnt_q == '0) begin
          state_d = setup_hit ? S_SETUP : S_IDLE;
        end else if (!PSEL) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - ONE;
          done  = (cnt_q == ONE);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_SETUP) begin
      idx_d = idx;
      ok_d  = addr_ok;
      wr_d  = PWRITE;
    end
  end

  always_comb begin
    wdat_d = wdat_q;
    rdat_d = rdat_q;
    if (done && wr_q && ok_q)
      wdat_d = PWDATA;
    if (done && !wr_q)
      rdat_d = ok_q ? mux_data : '0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ok_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      wdat_q  <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ok_q    <= ok_d;
      wr_q    <= wr_d;
      rdy_q   <= done;
      err_q   <= done && !ok_q;
      wen_q   <= done && wr_q && ok_q;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
    end
  end

  assign PREADY  = rdy_q;
  assign PSLVERR = err_q;
  assign wr_en   = wen_q;
  assign wr_data = wdat_q;
  assign PRDATA  = rdat_q;

endmodule
